// File: rtl/pe_in_seq.sv
// pe_in_seq -- front-end sequencer that builds the PE input packet for the
// CNN PE + pool/ReLU pipeline.
//
// A job is one kernel load followed by one activation stream:
//   IDLE  -> wait for start, latch the job size
//   LOAD  -> accept cfg_wdep+1 weight words, write them to PE buffer B
//   COMP  -> accept cfg_nvec+1 activation vectors, drive each onto A with
//            the B read address that pairs with it (cycles through 0..cfg_wdep)
//   DRAIN -> give the PE/pool pipeline a fixed time to empty, then pulse done
//
// Every packet output is a register loaded one cycle after the handshake
// that produced it. busy/pe_state/done are on that same output timeline.
// Because of this, the done cycle still shows busy=1 and pe_state=HOLD, and
// the cycle after it shows IDLE.
//
// Ports
//   clk, reset         rising-edge clock, async active-low reset
//   start              job start pulse (only honoured in IDLE)
//   cfg_wdep/cfg_nvec  weight count-1 / vector count-1, latched on start
//   w_valid/w_ready/w_data   weight stream (ready only in LOAD)
//   a_valid/a_ready/a_data   activation stream (ready only in COMP)
//   pe_state           0 IDLE, 1 LOAD, 2 COMP (A valid), 3 HOLD (no A beat)
//   wrb/wrb_addr/wrb_data    B-buffer write port
//   rdb_addr, A        B read address and activation vector to the PE
//   busy, done         job in progress / one-cycle end-of-job pulse

// One activation lane of the A output register.
module pe_in_lane #(
  parameter int DATA_WID = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [DATA_WID-1:0] d,
  output logic [DATA_WID-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)  q <= '0;
    else if (en) q <= d;
endmodule

module pe_in_seq #(
  parameter int DATA_WID  = 16,
  parameter int ICP_NUM   = 8,
  parameter int ADDR_B    = 6,
  parameter int DRAIN_CYC = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_B-1:0]           cfg_wdep,
  input  logic [15:0]                 cfg_nvec,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [DATA_WID-1:0]         w_data,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [ICP_NUM*DATA_WID-1:0] a_data,
  output logic [1:0]                  pe_state,
  output logic                        wrb,
  output logic [ADDR_B-1:0]           wrb_addr,
  output logic [DATA_WID-1:0]         wrb_data,
  output logic [ADDR_B-1:0]           rdb_addr,
  output logic [ICP_NUM*DATA_WID-1:0] A,
  output logic                        busy,
  output logic                        done
);
  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [1:0] PE_IDLE = 2'd0;
  localparam logic [1:0] PE_LOAD = 2'd1;
  localparam logic [1:0] PE_COMP = 2'd2;
  localparam logic [1:0] PE_HOLD = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_DRAIN} st_t;

  typedef struct packed {
    logic                en;
    logic [ADDR_B-1:0]   addr;
    logic [DATA_WID-1:0] data;
  } wr_beat_t;

  st_t st, st_nxt;

  logic [ADDR_B-1:0] wdep_q;
  logic [15:0]       nvec_q;
  logic [ADDR_B-1:0] wcnt;
  logic [ADDR_B-1:0] rcnt;
  logic [15:0]       vcnt;
  logic [DCW-1:0]    dcnt;

  logic start_acc, w_fire, a_fire, drain_end;

  wr_beat_t   wr_q;
  logic [1:0] pe_q;
  logic       busy_q, done_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= S_IDLE;
    else        st <= st_nxt;

  always_comb begin
    st_nxt    = st;
    w_ready   = 1'b0;
    a_ready   = 1'b0;
    start_acc = 1'b0;
    w_fire    = 1'b0;
    a_fire    = 1'b0;
    drain_end = 1'b0;
    case (st)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          st_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        w_fire  = w_valid;
        if (w_valid && (wcnt == wdep_q)) st_nxt = S_COMP;
      end
      S_COMP: begin
        // The PE never stalls, so every offered vector is taken.
        a_ready = 1'b1;
        a_fire  = a_valid;
        if (a_valid && (vcnt == nvec_q)) st_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        drain_end = (dcnt == DCW'(DRAIN_CYC - 1));
        if (drain_end) st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // ---------------- job counters ----------------
  // Limits come from the latched job size, so a counter is always left (or
  // wrapped explicitly) before it could run past its range in a way that
  // matters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdep_q <= '0;
      nvec_q <= '0;
      wcnt   <= '0;
      rcnt   <= '0;
      vcnt   <= '0;
      dcnt   <= '0;
    end else begin
      if (start_acc) begin
        wdep_q <= cfg_wdep;
        nvec_q <= cfg_nvec;
        wcnt   <= '0;
        rcnt   <= '0;
        vcnt   <= '0;
        dcnt   <= '0;
      end
      if (w_fire) wcnt <= wcnt + 1'b1;
      if (a_fire) begin
        // B read address walks the loaded kernel and wraps to its start.
        rcnt <= (rcnt == wdep_q) ? '0 : rcnt + 1'b1;
        vcnt <= vcnt + 1'b1;
      end
      if (st == S_DRAIN) dcnt <= dcnt + 1'b1;
    end
  end

  // ---------------- registered packet outputs ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q     <= '0;
      rdb_addr <= '0;
      pe_q     <= PE_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_q.en <= w_fire;
      if (w_fire) begin
        wr_q.addr <= wcnt;
        wr_q.data <= w_data;
      end
      if (a_fire) rdb_addr <= rcnt;
      // busy covers the done cycle: it tracks the state the FSM was in when
      // the outputs were loaded.
      busy_q <= (st != S_IDLE) || start_acc;
      done_q <= drain_end;
      case (st)
        S_IDLE:  pe_q <= start_acc ? PE_LOAD : PE_IDLE;
        S_LOAD:  pe_q <= PE_LOAD;
        S_COMP:  pe_q <= a_fire ? PE_COMP : PE_HOLD;
        S_DRAIN: pe_q <= PE_HOLD;
        default: pe_q <= PE_IDLE;
      endcase
    end
  end

  // A is held per lane; lanes only load on an accepted vector, so bubbles
  // and drain keep the last vector on the bus.
  logic [ICP_NUM-1:0][DATA_WID-1:0] a_lane_d, a_lane_q;
  assign a_lane_d = a_data;

  for (genvar g = 0; g < ICP_NUM; g++) begin : g_lane
    pe_in_lane #(.DATA_WID(DATA_WID)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (a_fire),
      .d     (a_lane_d[g]),
      .q     (a_lane_q[g])
    );
  end

  assign A        = a_lane_q;
  assign wrb      = wr_q.en;
  assign wrb_addr = wr_q.addr;
  assign wrb_data = wr_q.data;
  assign pe_state = pe_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
